ext_mem_responder: RTL and testbench
====================================

# ext_mem_responder

Memory-side responder for the external-memory request/valid protocol driven by the DMA. It stores 32-bit words and services one read or write request at a time. Each request is answered with a one-cycle `valid_extmem` pulse after a configurable latency. Stalls can be injected to stretch that latency. It acts as the off-chip memory model in block-level and top-level benches of the inverted residual block, and is synthesizable as an on-FPGA stand-in for DRAM.

## Interface
- `DEPTH`, 65536: number of 32-bit words stored; legal addresses are 0..DEPTH-1. Word-addressed.
- `LATENCY`, 4: cycles from request capture to the `valid_extmem` pulse. Must be ≥1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `request_extmem`  in  1  request from the DMA; held high until `valid_extmem` is seen.
- `write_extmem`  in  1  1 = write, 0 = read; stable while the request is high.
- `addr_extmem`  in  32  word address; stable while the request is high.
- `w_data`  in  32  write data; stable while the request is high.
- `stall`  in  1  test stall; freezes the latency counter while high.
- `preload_en`  in  1  backdoor write enable (bench or loader).
- `preload_addr`  in  32  backdoor address.
- `preload_data`  in  32  backdoor data.
- `valid_extmem`  out  1  one-cycle response pulse.
- `data_extmem`  out  32  read data; valid only while `valid_extmem`=1 on a read.
- `err`  out  1  pulses with `valid_extmem` when the address is ≥DEPTH.
- `n_reads`  out  32  count of completed reads, including errored ones.
- `n_writes`  out  32  count of completed writes, including errored ones.

## Operation
- FSM states:
  - IDLE → BUSY when `request_extmem`=1 is sampled. On that edge, capture addr/write/w_data into the `req_*` registers and load the counter with LATENCY-1.
  - BUSY: the counter decrements each cycle while `stall`=0 and holds while `stall`=1. At counter=0 with `stall`=0, go to RESP.
  - RESP: `valid_extmem`=1 for exactly one cycle, then go to IDLE.
- Read: `data_extmem` = mem[req_addr] during the RESP cycle; it is 0 in every other cycle.
- Write: mem[req_addr] ← req_data on the clock edge that ends the RESP cycle. `data_extmem` stays 0.
- Out of range (req_addr ≥ DEPTH):
  - `err`=1 during RESP;
  - read data is 0;
  - the write is discarded;
  - the counters still increment.
- Counters increment by 1 on the edge ending RESP and wrap at 2^32.
- Captured values are used; changes on the inputs during BUSY/RESP are ignored. This is a protocol violation and the responder takes no action on it.
- Requester rule: it must drop the request, or present the next transaction, on the cycle after `valid_extmem`.
  - The responder samples the request again in the IDLE cycle following RESP.
  - A request held high across that edge is treated as a new transaction.
- Preload: mem[preload_addr] ← preload_data in any state when preload_addr < DEPTH; otherwise it is ignored.
  - If a preload and a functional write hit the same address on the same edge, the functional write wins.
- Read-during-preload of the same word in the RESP cycle returns the old contents.

## Timing
- Request sampled high at edge t (IDLE) → `valid_extmem` high in the cycle after edge t+LATENCY, given no stall. Each stalled cycle adds 1.
- LATENCY=1: IDLE→BUSY(counter 0)→RESP, so valid is seen one cycle after capture.
- Back-to-back throughput: one transaction per LATENCY+2 cycles (capture, LATENCY-1 BUSY cycles, RESP, IDLE).
- `stall` is ignored in IDLE and RESP; RESP is never extended.
- Reset values: state IDLE; `valid_extmem`=0, `data_extmem`=0, `err`=0, `n_reads`=0, `n_writes`=0, counter 0.
- Reset in BUSY or RESP aborts the transaction with no response and no memory write. A write whose RESP edge coincides with `rst`=1 is not performed.
- Memory contents are not cleared by reset.
- Memory read is combinational from req_addr or registered at BUSY exit; either way it must be correct in the RESP cycle.

## Test plan
- Preload mem[0x10]=0xDEADBEEF; read request at 0x10 with LATENCY=4 → `valid_extmem` exactly one cycle, 4 cycles after capture, with `data_extmem`=0xDEADBEEF; `n_reads`=1.
- Write 0x12345678 to 0x20, then read 0x20 back-to-back with the request held high and the address switched on the cycle after valid → read returns 0x12345678. The second valid arrives LATENCY+2 cycles after the first.
- `stall` held high for 3 cycles during BUSY → valid delayed by exactly 3 cycles. Data is unchanged.
- Read at address DEPTH → `err`=1 and `data_extmem`=0 in the valid cycle. Write at DEPTH+5 → no memory change (mem[5] untouched); `n_writes` increments.
- `rst` pulsed 2 cycles after capturing a write of 0xA5A5A5A5 to 0x30 → no valid pulse, mem[0x30] keeps its old value, outputs 0. The next request is serviced normally.
- Same-edge preload (0x30 ← 0x1) and functional write (0x30 ← 0x2) → a later read of 0x30 returns 0x2.

Source files
------------

// File: rtl/ext_mem_responder.sv
// Word-addressed memory responder for the DMA request/valid protocol: one
// transaction at a time, answered with a single-cycle valid after LATENCY cycles.
module ext_mem_responder #(
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_extmem,
  input  logic        write_extmem,
  input  logic [31:0] addr_extmem,
  input  logic [31:0] w_data,
  input  logic        stall,
  input  logic        preload_en,
  input  logic [31:0] preload_addr,
  input  logic [31:0] preload_data,
  output logic        valid_extmem,
  output logic [31:0] data_extmem,
  output logic        err,
  output logic [31:0] n_reads,
  output logic [31:0] n_writes,
  output logic [1:0]  state_dbg
);

  // Handshake: the requester holds request_extmem (with stable write/addr/data)
  // until it sees the one-cycle valid_extmem; a request still high in the IDLE
  // cycle after RESP is taken as a new transaction.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [32:0] DEPTH_W = 33'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          capture, busy_exit, resp_end;

  logic          req_write;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic          req_in_range;
  logic          pl_in_range;
  logic [31:0]   rd_q;

  logic [31:0]   mem [DEPTH];

  assign req_in_range = ({1'b0, req_addr} < DEPTH_W);
  assign pl_in_range  = ({1'b0, preload_addr} < DEPTH_W);
  assign resp_end     = (state == S_RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    busy_exit = 1'b0;
    case (state)
      S_IDLE: begin
        if (request_extmem) begin
          state_nxt = S_BUSY;
          cnt_nxt   = CW'(LATENCY - 1);
          capture   = 1'b1;
        end
      end
      S_BUSY: begin
        if (!stall) begin
          if (cnt == '0) begin
            state_nxt = S_RESP;
            busy_exit = 1'b1;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data is registered on BUSY exit so the array maps onto block RAM;
  // rd_q is zero in every cycle except RESP of an in-range read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      n_reads   <= '0;
      n_writes  <= '0;
      rd_q      <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        req_write <= write_extmem;
        req_addr  <= addr_extmem;
        req_data  <= w_data;
      end
      if (resp_end) begin
        if (req_write) n_writes <= n_writes + 32'd1;
        else           n_reads  <= n_reads + 32'd1;
      end
      if (busy_exit && !req_write && req_in_range) rd_q <= mem[req_addr[AW-1:0]];
      else                                         rd_q <= '0;
    end
  end

  // Functional write is issued after the preload so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (preload_en && pl_in_range)
      mem[preload_addr[AW-1:0]] <= preload_data;
    if (resp_end && req_write && req_in_range && !rst)
      mem[req_addr[AW-1:0]] <= req_data;
  end

  assign valid_extmem = (state == S_RESP);
  assign err          = valid_extmem && !req_in_range;
  assign data_extmem  = rd_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: latency, back-to-back, stall, range
// errors, reset abort and preload/write collision.
module tb_ext_mem_responder;

  localparam int DEPTH   = 65536;
  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        request_extmem, write_extmem, stall, preload_en;
  logic [31:0] addr_extmem, w_data, preload_addr, preload_data;
  logic        valid_extmem, err;
  logic [31:0] data_extmem, n_reads, n_writes;
  logic [1:0]  state_dbg;

  ext_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .request_extmem(request_extmem), .write_extmem(write_extmem),
    .addr_extmem(addr_extmem), .w_data(w_data), .stall(stall),
    .preload_en(preload_en), .preload_addr(preload_addr), .preload_data(preload_data),
    .valid_extmem(valid_extmem), .data_extmem(data_extmem), .err(err),
    .n_reads(n_reads), .n_writes(n_writes), .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          exp_reads  = 0;
  int          exp_writes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    @(posedge clk);
    #1 preload_en = 1'b0;
  endtask

  // Issues one request and returns at the negedge of the valid cycle.
  // lat = clock edges from capture to the edge that raises valid.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int stall_from, input int stall_len, input bit hold,
                        input bit pl, input logic [31:0] pl_a, input logic [31:0] pl_d,
                        output int lat, output int vcyc,
                        output logic [31:0] rdata, output logic rerr);
    bit got;
    @(negedge clk);
    check("idle_valid_low", 32'(valid_extmem), 32'd0);
    check("idle_data_zero", data_extmem, 32'd0);
    request_extmem = 1'b1; write_extmem = wr; addr_extmem = a; w_data = d;
    @(posedge clk);
    lat = 0; got = 1'b0; vcyc = 0; rdata = '0; rerr = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      if (valid_extmem) begin
        got = 1'b1;
        break;
      end
      lat++;
      stall = (lat > stall_from) && (lat <= stall_from + stall_len);
    end
    stall = 1'b0;
    check("valid_seen", 32'(got), 32'd1);
    vcyc  = cyc;
    rdata = data_extmem;
    rerr  = err;
    if (!hold) request_extmem = 1'b0;
    if (pl) begin
      preload_en = 1'b1; preload_addr = pl_a; preload_data = pl_d;
      @(posedge clk);
      #1 preload_en = 1'b0;
    end
  endtask

  // Just after the edge that ends RESP: valid is gone, counters updated.
  task automatic check_after_resp(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_valid_one_cycle"}, 32'(valid_extmem), 32'd0);
    check({tag, "_n_reads"}, n_reads, 32'(exp_reads));
    check({tag, "_n_writes"}, n_writes, 32'(exp_writes));
  endtask

  // ---------------- stimulus ----------------
  int          lat, vcyc, vcyc_prev, vcount;
  logic [31:0] rdata;
  logic        rerr;

  initial begin
    rst = 1'b1; request_extmem = 1'b0; write_extmem = 1'b0; addr_extmem = '0;
    w_data = '0; stall = 1'b0; preload_en = 1'b0; preload_addr = '0; preload_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid_extmem), 32'd0);
    check("rst_data", data_extmem, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_n_reads", n_reads, 32'd0);
    check("rst_n_writes", n_writes, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    preload(32'h10, 32'hDEADBEEF);
    preload(32'h30, 32'h11111111);
    preload(32'h5,  32'h55555555);

    // basic read
    exp_q.push_back(32'hDEADBEEF);
    do_txn(1'b0, 32'h10, '0, 0, 0, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("rd10_latency", 32'(lat), 32'(LATENCY));
    check("rd10_data", rdata, exp_q.pop_front());
    check("rd10_err", 32'(rerr), 32'd0);
    exp_reads++;
    check_after_resp("rd10");

    // write then back-to-back read with request held
    do_txn(1'b1, 32'h20, 32'h12345678, 0, 0, 1'b1, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("wr20_latency", 32'(lat), 32'(LATENCY));
    check("wr20_data_zero", rdata, 32'd0);
    vcyc_prev = vcyc;
    exp_writes++;
    exp_q.push_back(32'h12345678);
    do_txn(1'b0, 32'h20, '0, 0, 0, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("b2b_spacing", 32'(vcyc - vcyc_prev), 32'(LATENCY + 2));
    check("rd20_data", rdata, exp_q.pop_front());
    exp_reads++;
    check_after_resp("b2b");

    // three stalled BUSY cycles
    exp_q.push_back(32'hDEADBEEF);
    do_txn(1'b0, 32'h10, '0, 1, 3, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("stall_latency", 32'(lat), 32'(LATENCY + 3));
    check("stall_data", rdata, exp_q.pop_front());
    exp_reads++;
    check_after_resp("stall");

    // out-of-range read and write
    do_txn(1'b0, 32'(DEPTH), '0, 0, 0, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("oor_rd_err", 32'(rerr), 32'd1);
    check("oor_rd_data", rdata, 32'd0);
    exp_reads++;
    check_after_resp("oor_rd");
    do_txn(1'b1, 32'(DEPTH + 5), 32'h00000BAD, 0, 0, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("oor_wr_err", 32'(rerr), 32'd1);
    exp_writes++;
    check_after_resp("oor_wr");
    exp_q.push_back(32'h55555555);
    do_txn(1'b0, 32'h5, '0, 0, 0, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("mem5_untouched", rdata, exp_q.pop_front());
    check("mem5_err", 32'(rerr), 32'd0);
    exp_reads++;
    check_after_resp("rd5");

    // reset two cycles after capturing a write
    @(negedge clk);
    request_extmem = 1'b1; write_extmem = 1'b1; addr_extmem = 32'h30; w_data = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; request_extmem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_extmem) vcount++;
    end
    check("abort_no_valid", 32'(vcount), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    check("abort_data", data_extmem, 32'd0);
    exp_reads = 0; exp_writes = 0;
    check("abort_n_reads", n_reads, 32'd0);
    check("abort_n_writes", n_writes, 32'd0);
    exp_q.push_back(32'h11111111);
    do_txn(1'b0, 32'h30, '0, 0, 0, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("abort_mem30", rdata, exp_q.pop_front());
    check("post_abort_latency", 32'(lat), 32'(LATENCY));
    exp_reads++;
    check_after_resp("post_abort");

    // preload and functional write on the same edge
    do_txn(1'b1, 32'h30, 32'h2, 0, 0, 1'b0, 1'b1, 32'h30, 32'h1, lat, vcyc, rdata, rerr);
    exp_writes++;
    exp_q.push_back(32'h2);
    do_txn(1'b0, 32'h30, '0, 0, 0, 1'b0, 1'b0, '0, '0, lat, vcyc, rdata, rerr);
    check("collide_mem30", rdata, exp_q.pop_front());
    exp_reads++;
    check_after_resp("collide");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
